// File: rtl/mem_pkg.sv
// Shared constants for the CPU memory responder.
// FSM encoding, default widths and RW polarity.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM for the memory responder.
// Clocked write, read port follows the address.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // commit a write on the clock edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory side of the CPU handshake: MAR, MDR, RAM, wait states.
// Optional MAR range check enabled by MEM_ADDR_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_EN,
  input  logic              BUS_MEM,
  input  logic              RW,
  input  logic              MEM_EN,
  input  logic              MDR_OUT,
  input  logic              MEM_BUS,
  output logic              MFC,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              busy
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic              mem_err
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rdata;
  logic              rw_q;
  logic              mfc_q;
  logic              fin;
  logic              bad;
  logic              we;

  assign fin     = (state == ST_WAIT) && (cnt == 4'd0);
  assign we      = fin && (rw_q == RW_WRITE) && !bad && !reset;
  assign MFC     = mfc_q;
  assign busy    = (state != ST_IDLE);
  assign bus_out = mdr;
  assign bus_oe  = MDR_OUT & MEM_BUS;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (mar),
    .wdata (mdr),
    .rdata (rdata)
  );

  // request FSM with MAR/MDR loads and the wait-state counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mar   <= '0;
      mdr   <= '0;
      rw_q  <= RW_READ;
      mfc_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MAR_EN) mar <= bus_in[ADDR_W-1:0];
          if (BUS_MEM) mdr <= bus_in;
          if (MEM_EN) begin
            rw_q  <= RW;
            cnt   <= CNT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            if (rw_q == RW_READ && !bad) mdr <= rdata;
            mfc_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!MEM_EN) begin
            mfc_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  // out-of-range MAR flag and its error report alongside MFC
  always_ff @(posedge clk) begin
    if (reset) begin
      bad     <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && MAR_EN)
        bad <= |bus_in[DATA_W-1:ADDR_W];
      if (fin)
        mem_err <= bad;
      else if (state == ST_DONE && !MEM_EN)
        mem_err <= 1'b0;
    end
  end
`else
  logic unused_hi;
  assign bad       = 1'b0;
  assign unused_hi = ^bus_in[DATA_W-1:ADDR_W];
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Table vectors, directed corner cases, random ops vs a model.
module tb_mem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        MAR_EN, BUS_MEM, RW, MEM_EN, MDR_OUT, MEM_BUS;
  logic        MFC, bus_oe, busy;
  logic [15:0] bus_out;
`ifdef MEM_ADDR_CHECK_EN
  logic        mem_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (16),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus_in  (bus_in),
    .MAR_EN  (MAR_EN),
    .BUS_MEM (BUS_MEM),
    .RW      (RW),
    .MEM_EN  (MEM_EN),
    .MDR_OUT (MDR_OUT),
    .MEM_BUS (MEM_BUS),
    .MFC     (MFC),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .busy    (busy)
`ifdef MEM_ADDR_CHECK_EN
    ,
    .mem_err (mem_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl [10];

  logic [15:0] ref_mem [16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic me, input logic bm,
                      input logic [15:0] v);
    MAR_EN = me;
    BUS_MEM = bm;
    bus_in = v;
    tick();
    MAR_EN = 1'b0;
    BUS_MEM = 1'b0;
  endtask

  task automatic access(input logic rw, input bit drop);
    int lat;
    RW = rw;
    MEM_EN = 1'b1;
    lat = 0;
    while (!MFC && lat < 40) begin
      tick();
      lat++;
      if (drop) MEM_EN = 1'b0;
      RW = 1'($urandom_range(0, 1));
    end
    chk("latency", lat, WC + 2);
    MEM_EN = 1'b0;
    tick();
    chk("mfc_clear", {busy, MFC}, 2'b00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    load(1'b1, 1'b0, a);
    load(1'b0, 1'b1, d);
    access(1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    load(1'b1, 1'b0, a);
    access(1'b1, 1'b0);
    d = bus_out;
  endtask

  initial begin
    logic [15:0] d;
    int n;

    reset = 1'b1;
    bus_in = '0;
    MAR_EN = 0; BUS_MEM = 0; RW = 1; MEM_EN = 0;
    MDR_OUT = 0; MEM_BUS = 0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_mfc", MFC, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe", bus_oe, 1'b0);
    chk("rst_bus_out", bus_out, 16'h0000);
`ifdef MEM_ADDR_CHECK_EN
    chk("rst_err", mem_err, 1'b0);
`endif
    MDR_OUT = 1;
    #1 chk("oe_partial", bus_oe, 1'b0);
    MEM_BUS = 1;
    #1 chk("oe_both", bus_oe, 1'b1);
    MDR_OUT = 0;
    #1 chk("oe_partial2", bus_oe, 1'b0);
    MEM_BUS = 0;

    load(1'b1, 1'b0, 16'h0005);
    load(1'b0, 1'b1, 16'hBEEF);
    access(1'b0, 1'b0);
    rd(16'h0006, d);
    rd(16'h0005, d);
    MDR_OUT = 1; MEM_BUS = 1;
    #1;
    chk("rd_beef", bus_out, 16'hBEEF);
    chk("rd_beef_oe", bus_oe, 1'b1);
    MDR_OUT = 0; MEM_BUS = 0;

    tbl[0] = '{1'b1, 16'h0010, 16'hAAAA};
    tbl[1] = '{1'b1, 16'h0011, 16'h5555};
    tbl[2] = '{1'b0, 16'h0010, 16'hAAAA};
    tbl[3] = '{1'b1, 16'h0010, 16'h1234};
    tbl[4] = '{1'b0, 16'h0010, 16'h1234};
    tbl[5] = '{1'b0, 16'h0011, 16'h5555};
    tbl[6] = '{1'b1, 16'h00FF, 16'hFFFF};
    tbl[7] = '{1'b1, 16'h0000, 16'h0001};
    tbl[8] = '{1'b0, 16'h00FF, 16'hFFFF};
    tbl[9] = '{1'b0, 16'h0000, 16'h0001};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
      end else begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl%0d", i), d, tbl[i].data);
      end
    end

    wr(16'h0044, 16'h4444);
    load(1'b1, 1'b0, 16'h0044);
    RW = 1'b1;
    MEM_EN = 1'b1;
    n = 0;
    while (!MFC && n < 40) begin
      tick();
      n++;
    end
    chk("hold_lat", n, WC + 2);
    BUS_MEM = 1'b1;
    bus_in = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_mfc", MFC, 1'b1);
      chk("hold_mdr", bus_out, 16'h4444);
    end
    BUS_MEM = 1'b0;
    MEM_EN = 1'b0;
    tick();
    chk("hold_idle", {busy, MFC}, 2'b00);

    wr(16'h0033, 16'h3333);
    load(1'b1, 1'b0, 16'h0020);
    load(1'b0, 1'b1, 16'hCAFE);
    RW = 1'b0;
    MEM_EN = 1'b1;
    tick();
    MAR_EN = 1'b1;
    bus_in = 16'h0033;
    tick();
    MAR_EN = 1'b0;
    n = 0;
    while (!MFC && n < 40) begin
      tick();
      n++;
    end
    chk("marwait_mfc", MFC, 1'b1);
    MEM_EN = 1'b0;
    tick();
    rd(16'h0033, d);
    chk("marwait_33", d, 16'h3333);
    rd(16'h0020, d);
    chk("marwait_20", d, 16'hCAFE);

    wr(16'h0009, 16'h9999);
    load(1'b1, 1'b0, 16'h0009);
    load(1'b0, 1'b1, 16'h1234);
    RW = 1'b0;
    MEM_EN = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    MEM_EN = 1'b0;
    tick();
    reset = 1'b0;
    chk("abort_mfc", MFC, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_mdr", bus_out, 16'h0000);
    rd(16'h0009, d);
    chk("abort_mem", d, 16'h9999);

    wr(16'h0005, 16'h0077);
    load(1'b1, 1'b0, 16'h0105);
    load(1'b0, 1'b1, 16'hABCD);
    RW = 1'b0;
    MEM_EN = 1'b1;
    n = 0;
    while (!MFC && n < 40) begin
      tick();
      n++;
    end
    chk("chk_mfc", MFC, 1'b1);
`ifdef MEM_ADDR_CHECK_EN
    chk("chk_err_set", mem_err, 1'b1);
`endif
    MEM_EN = 1'b0;
    tick();
`ifdef MEM_ADDR_CHECK_EN
    chk("chk_err_clr", mem_err, 1'b0);
    rd(16'h0005, d);
    chk("chk_mem", d, 16'h0077);
`else
    rd(16'h0005, d);
    chk("wrap_mem", d, 16'hABCD);
`endif

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      wr(16'h0040 + 16'(i), ref_mem[i]);
    end
    for (int k = 0; k < 120; k++) begin
      int a;
      logic [15:0] v;
      a = $urandom_range(0, 15);
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        load(1'b1, 1'b0, 16'h0040 + 16'(a));
        load(1'b0, 1'b1, v);
        access(1'b0, 1'($urandom_range(0, 1)));
        ref_mem[a] = v;
      end else begin
        load(1'b1, 1'b0, 16'h0040 + 16'(a));
        access(1'b1, 1'($urandom_range(0, 1)));
        chk($sformatf("rand_rd%0d", a), bus_out, ref_mem[a]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
